wide_alu_seq: RTL and testbench
===============================

# wide_alu_seq

Two-cycle sequencer that runs 16-bit arithmetic and logic operations through the existing 8-bit ALU. It sits directly upstream of the ALU: it drives the ALU's operands, opcode and carry-in, and consumes its result, carry-out and zero flag. It splits each operation into a low-byte pass and a high-byte pass, chains the carry/borrow between them, and reports a 16-bit result with combined flags. Both this block and the ALU are instantiated by the datapath parent; this block does not instantiate the ALU.

## Interface
- No parameters. Data width is fixed at 16 (two 8-bit ALU passes).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block can accept
- op  in  4  function code from shared defines: ADD_FN, ADDC_FN, SUB_FN, SUBC_FN, AND_FN, OR_FN, XOR_FN, MASK_FN
- a, b  in  16  operands
- carry_in  in  1  carry/borrow-in for ADDC_FN/SUBC_FN; ignored for all other ops
- alu_in1, alu_in2  out  8  ALU operands
- alu_op  out  4  ALU function code
- alu_cin  out  1  ALU carry-in
- alu_out  in  8  ALU result
- alu_cout  in  1  ALU carry/borrow-out
- alu_z  in  1  ALU zero flag
- result  out  16  registered result
- carry_out  out  1  registered final carry/borrow
- zero  out  1  registered; 1 when all 16 result bits are 0
- err  out  1  registered; 1 when the last accepted op was unsupported
- busy  out  1  high in LO and HI
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LO, HI, DONE.
- **IDLE**
  - On start, capture op, a, b and carry_in into internal registers and go to LO.
  - Otherwise stay in IDLE.
- **LO** (low byte)
  - alu_in1 = a[7:0], alu_in2 = b[7:0].
  - ADD/ADDC map to ADDC_FN; SUB/SUBC map to SUBC_FN.
  - alu_cin = captured carry_in for ADDC/SUBC, 0 for ADD/SUB.
  - Logic ops pass their code unchanged, with alu_cin = 0.
  - Latch alu_out into result[7:0], alu_cout into the internal carry, and alu_z into z_lo.
  - Go to HI.
- **HI** (high byte)
  - alu_in1 = a[15:8], alu_in2 = b[15:8].
  - Arithmetic ops use ADDC_FN/SUBC_FN with alu_cin = the internal carry. Logic ops are as in LO.
  - Latch result[15:8] = alu_out, carry_out = alu_cout, zero = z_lo & alu_z.
  - Go to DONE.
- **DONE**
  - done = 1 for this cycle.
  - If start is high, capture the new request and go to LO (back-to-back). Otherwise go to IDLE.
- **IDLE/DONE ALU drive:** alu_in1 = alu_in2 = 0, alu_op = ADD_FN, alu_cin = 0.
- **Carry semantics**
  - Carries are the ALU's 9th bit; for subtraction this is borrow (1 = borrow).
  - Logic ops produce carry_out = 0.
- **Unsupported op** (any code not listed above, including ADD_SIGNED)
  - Still takes the full 3-cycle sequence with the ALU held in its idle drive.
  - Ends with result = 0, carry_out = 0, zero = 1, err = 1.
  - Every supported op clears err.
- **Start handling:** start in LO or HI is ignored; the request is not queued. Operand changes after capture have no effect.
- **Reset**
  - Reset value of every registered output: result = 0, carry_out = 0, zero = 0, err = 0.
  - State returns to IDLE.
  - Reset mid-operation aborts it with no done pulse.
  - Reset takes priority over start.

## Timing
- Start sampled high in IDLE at edge 0: LO during cycle 1, HI during cycle 2, DONE during cycle 3.
- result and flags are valid from cycle 3 and hold until the next HI completes.
- Throughput is one op per 3 cycles when start is held or re-asserted in DONE.
- The ALU is combinational, so the ALU drive outputs are combinational from state and captured registers. All flag/result capture happens on the clock edge ending LO or HI.
- busy = (state == LO || state == HI). busy and done are never high together.

## Structure
- Shared defines (existing include) hold the ALU function codes. Add a state typedef {IDLE, LO, HI, DONE} there for use by the bench.
- The op-mapping logic (op plus pass → alu_op, alu_cin) is a local function in this module.
- No sub-module.

## Test plan
- ADD a=0x00FF, b=0x0001 → result=0x0100, carry_out=0, zero=0; done exactly 3 cycles after start.
- ADD a=0xFFFF, b=0x0001 → result=0x0000, carry_out=1, zero=1. Then ADDC a=0x1234, b=0x0000, carry_in=1 → 0x1235.
- SUB a=0x0100, b=0x0001 → 0x00FF, carry_out=0. Then SUB a=0x0000, b=0x0001 → 0xFFFF, carry_out=1.
- XOR a=b=0xA5A5 → 0x0000, zero=1, carry_out=0. Then MASK a=b=0xFFFF → 0x0000. Then OR a=0x0F00, b=0x00F0 → 0x0FF0.
- Back-to-back start held high across two ops → done pulses 3 cycles apart. A start pulse during LO is ignored and produces no extra done.
- rst asserted in HI → next cycle state IDLE, result=0, no done. An op of ADD_SIGNED → err=1, result=0, zero=1.

Source files
------------

// File: rtl/wide_alu_seq_pkg.sv
// Shared definitions for the 16-bit sequencer that drives the 8-bit ALU:
// ALU function codes, widths and the sequencer state type.
package wide_alu_seq_pkg;

  localparam int ALU_W  = 8;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ADD_FN     = 4'd0;
  localparam logic [OP_W-1:0] ADDC_FN    = 4'd1;
  localparam logic [OP_W-1:0] SUB_FN     = 4'd2;
  localparam logic [OP_W-1:0] SUBC_FN    = 4'd3;
  localparam logic [OP_W-1:0] AND_FN     = 4'd4;
  localparam logic [OP_W-1:0] OR_FN      = 4'd5;
  localparam logic [OP_W-1:0] XOR_FN     = 4'd6;
  localparam logic [OP_W-1:0] MASK_FN    = 4'd7;
  localparam logic [OP_W-1:0] ADD_SIGNED = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // ALU control for one byte pass.
  typedef struct packed {
    logic [OP_W-1:0] fn;
    logic            cin;
  } alu_ctl_t;

  function automatic logic is_supported(input logic [OP_W-1:0] fn);
    logic ok;
    ok = 1'b0;
    case (fn)
      ADD_FN, ADDC_FN, SUB_FN, SUBC_FN,
      AND_FN, OR_FN, XOR_FN, MASK_FN: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_arith(input logic [OP_W-1:0] fn);
    return (fn == ADD_FN) || (fn == ADDC_FN) || (fn == SUB_FN) || (fn == SUBC_FN);
  endfunction

endpackage

// File: rtl/wide_alu_seq.sv
// Runs a 16-bit operation as two chained passes (low byte, then high byte)
// through an external combinational 8-bit ALU and registers the 16-bit outcome.
module wide_alu_seq
  import wide_alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [ALU_W-1:0]  alu_in1,
  output logic [ALU_W-1:0]  alu_in2,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_cin,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_cout,
  input  logic              alu_z,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero,
  output logic              err,
  output logic              busy,
  output logic              done
);

  seq_state_t state_reg, state_next;

  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              cin_reg;

  logic              carry_reg;
  logic              z_lo_reg;
  logic [ALU_W-1:0]  res_lo_reg;

  logic [DATA_W-1:0] result_reg;
  logic              carry_out_reg;
  logic              zero_reg;
  logic              err_reg;

  logic              capture;
  logic              op_ok;
  alu_ctl_t          ctl;

  // Arithmetic always runs as the carry-chained variant so the high pass can
  // consume the low pass's carry/borrow; only the low pass honours carry_in,
  // and only for ADDC/SUBC.
  function automatic alu_ctl_t map_op(
    input logic [OP_W-1:0] fn,
    input logic            hi_pass,
    input logic            cap_cin,
    input logic            chain
  );
    alu_ctl_t c;
    c.fn  = ADD_FN;
    c.cin = 1'b0;
    case (fn)
      ADD_FN, ADDC_FN: begin
        c.fn  = ADDC_FN;
        c.cin = hi_pass ? chain : ((fn == ADDC_FN) && cap_cin);
      end
      SUB_FN, SUBC_FN: begin
        c.fn  = SUBC_FN;
        c.cin = hi_pass ? chain : ((fn == SUBC_FN) && cap_cin);
      end
      AND_FN, OR_FN, XOR_FN, MASK_FN: begin
        c.fn  = fn;
        c.cin = 1'b0;
      end
      default: begin
        c.fn  = ADD_FN;
        c.cin = 1'b0;
      end
    endcase
    return c;
  endfunction

  assign capture = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign op_ok   = is_supported(op_reg);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = start ? LO : IDLE;
      LO:      state_next = HI;
      HI:      state_next = DONE;
      DONE:    state_next = start ? LO : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: ALU drive is combinational from state and captured request.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_op  = ADD_FN;
    alu_cin = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    ctl     = '0;
    case (state_reg)
      LO: begin
        busy = 1'b1;
        if (op_ok) begin
          ctl     = map_op(op_reg, 1'b0, cin_reg, 1'b0);
          alu_in1 = a_reg[ALU_W-1:0];
          alu_in2 = b_reg[ALU_W-1:0];
          alu_op  = ctl.fn;
          alu_cin = ctl.cin;
        end
      end
      HI: begin
        busy = 1'b1;
        if (op_ok) begin
          ctl     = map_op(op_reg, 1'b1, cin_reg, carry_reg);
          alu_in1 = a_reg[DATA_W-1:ALU_W];
          alu_in2 = b_reg[DATA_W-1:ALU_W];
          alu_op  = ctl.fn;
          alu_cin = ctl.cin;
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Request capture and per-pass latching. The visible result only changes at
  // the end of HI so it holds steady for the whole next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= ADD_FN;
      a_reg         <= '0;
      b_reg         <= '0;
      cin_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      z_lo_reg      <= 1'b0;
      res_lo_reg    <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      zero_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (capture) begin
        op_reg  <= op;
        a_reg   <= a;
        b_reg   <= b;
        cin_reg <= carry_in;
      end
      case (state_reg)
        LO: begin
          res_lo_reg <= alu_out;
          carry_reg  <= alu_cout;
          z_lo_reg   <= alu_z;
        end
        HI: begin
          if (op_ok) begin
            result_reg    <= {alu_out, res_lo_reg};
            carry_out_reg <= is_arith(op_reg) ? alu_cout : 1'b0;
            zero_reg      <= z_lo_reg & alu_z;
            err_reg       <= 1'b0;
          end else begin
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            zero_reg      <= 1'b1;
            err_reg       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign zero      = zero_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_wide_alu_seq.sv
// Bench for wide_alu_seq: reference 8-bit ALU, 16-bit outcome/timeline model,
// per-cycle compare process, and directed vectors with literal expectations.
module tb_wide_alu_seq;
  import wide_alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, carry_in;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic [7:0]  alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_cout, alu_z;
  logic [15:0] result;
  logic        carry_out, zero, err, busy, done;

  int checks = 0;
  int errors = 0;

  wide_alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .carry_in(carry_in),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z),
    .result(result), .carry_out(carry_out), .zero(zero), .err(err),
    .busy(busy), .done(done)
  );

  // Reference 8-bit ALU; bit 8 is carry for add, borrow for subtract.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_op)
      ADD_FN:  alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
      ADDC_FN: alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'd0, alu_cin};
      SUB_FN:  alu_sum = {1'b0, alu_in1} - {1'b0, alu_in2};
      SUBC_FN: alu_sum = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'd0, alu_cin};
      AND_FN:  alu_sum = {1'b0, alu_in1 & alu_in2};
      OR_FN:   alu_sum = {1'b0, alu_in1 | alu_in2};
      XOR_FN:  alu_sum = {1'b0, alu_in1 ^ alu_in2};
      MASK_FN: alu_sum = {1'b0, alu_in1 & ~alu_in2};
      default: alu_sum = '0;
    endcase
    alu_out  = alu_sum[7:0];
    alu_cout = alu_sum[8];
    alu_z    = (alu_sum[7:0] == 8'd0);
  end

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        err;
  } outcome_t;

  // Whole-word outcome straight from 17-bit arithmetic.
  function automatic outcome_t predict(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                                       input logic ci);
    outcome_t o;
    logic [16:0] w;
    o.err = 1'b0;
    case (f)
      ADD_FN:  w = {1'b0, x} + {1'b0, y};
      ADDC_FN: w = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      SUB_FN:  w = {1'b0, x} - {1'b0, y};
      SUBC_FN: w = {1'b0, x} - {1'b0, y} - {16'd0, ci};
      AND_FN:  w = {1'b0, x & y};
      OR_FN:   w = {1'b0, x | y};
      XOR_FN:  w = {1'b0, x ^ y};
      MASK_FN: w = {1'b0, x & ~y};
      default: begin w = '0; o.err = 1'b1; end
    endcase
    o.res  = w[15:0];
    o.cout = w[16];
    o.zero = o.err ? 1'b1 : (w[15:0] == 16'd0);
    return o;
  endfunction

  // Timeline model: age = cycles since the last accepted request (-1 = none).
  int       age = -1;
  outcome_t pend = '0;
  outcome_t held = '0;

  always @(posedge clk) begin
    if (rst) begin
      age  = -1;
      held = '0;
    end else if (age == 1) begin
      age = 2;
    end else if (age == 2) begin
      age  = 3;
      held = pend;
    end else if (start) begin
      pend = predict(op, a, b, carry_in);
      age  = 1;
    end else if (age == 3) begin
      age = 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic in_flight;
    in_flight = (age == 1) || (age == 2);
    check("busy", busy, in_flight);
    check("done", done, age == 3);
    check("result", result, held.res);
    check("carry_out", carry_out, held.cout);
    check("zero", zero, held.zero);
    check("err", err, held.err);
    if (!in_flight || pend.err) begin
      check("idle_drive", {alu_in1, alu_in2, alu_op, alu_cin}, {8'd0, 8'd0, ADD_FN, 1'b0});
    end
  end

  task automatic run_op(input string tag, input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic [15:0] e_res, input logic e_c, input logic e_z,
                        input logic e_err);
    int k;
    @(negedge clk);
    op = f; a = x; b = y; carry_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
    k = 1;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 3);
    check({tag, "_result"}, result, e_res);
    check({tag, "_carry"}, carry_out, e_c);
    check({tag, "_zero"}, zero, e_z);
    check({tag, "_err"}, err, e_err);
    $display("%s op=%0d a=%h b=%h cin=%b -> result=%h carry=%b zero=%b err=%b latency=%0d",
             tag, f, x, y, ci, result, carry_out, zero, err, k);
  endtask

  initial begin
    int k;
    int dones;
    rst = 1'b1; start = 1'b0; op = ADD_FN; a = '0; b = '0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 16'h0000);
    check("reset_flags", {carry_out, zero, err, busy, done}, 5'b00000);
    rst = 1'b0;

    run_op("add_lo_carry", ADD_FN,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",     ADD_FN,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("addc_cin",     ADDC_FN, 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0);
    run_op("add_cin_ign",  ADD_FN,  16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow",   SUB_FN,  16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);
    run_op("sub_under",    SUB_FN,  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("subc_bin",     SUBC_FN, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("xor_zero",     XOR_FN,  16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("mask_all",     MASK_FN, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("or_mix",       OR_FN,   16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    run_op("and_mix",      AND_FN,  16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    op = ADD_FN; a = 16'h0001; b = 16'h0002; carry_in = 1'b0; start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 10);
    check("b2b_first_latency", k, 3);
    check("b2b_first_result", result, 16'h0003);
    $display("b2b_first op=ADD a=0001 b=0002 -> result=%h after %0d cycles", result, k);
    op = SUB_FN; a = 16'h0010; b = 16'h0001;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 10);
    start = 1'b0;
    check("b2b_spacing", k, 3);
    check("b2b_second_result", result, 16'h000F);
    $display("b2b_second op=SUB a=0010 b=0001 -> result=%h spacing=%0d", result, k);
    @(negedge clk);

    // A start pulse during LO must be dropped.
    @(negedge clk);
    op = ADD_FN; a = 16'h0100; b = 16'h0200; start = 1'b1;
    @(negedge clk);
    op = SUB_FN; a = 16'h0005; b = 16'h0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 7; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("lo_start_dones", dones, 1);
    check("lo_start_result", result, 16'h0300);
    $display("lo_start op=ADD a=0100 b=0200 (+start in LO) -> result=%h dones=%0d", result, dones);

    run_op("unsupported",  ADD_SIGNED, 16'h1234, 16'h4321, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Reset during HI aborts the op without a done pulse.
    @(negedge clk);
    op = ADD_FN; a = 16'h00FF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_hi_busy", busy, 1'b0);
    check("rst_hi_state", {result, carry_out, zero, err, done}, 20'h0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_hi_no_done", dones, 0);
    $display("rst_in_hi op=ADD a=00FF b=0001 -> result=%h err=%b dones=%0d", result, err, dones);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = ADD_FN; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", busy, 1'b0);
    $display("rst_priority start+rst -> busy=%b", busy);

    run_op("unsupp_again", 4'hF,    16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    run_op("err_clears",   ADD_FN,  16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
